mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single main-memory port between the instruction cache and data cache of the pipelined MIPS core. Each cache miss becomes a line-sized burst request; the arbiter grants one requester at a time, sequences `BURST_LEN` word beats to memory, and routes read data and acknowledgements back. It sits between the two caches and the memory model. While a refill is outstanding, the caches hold `ihit` and `dhit` low, which stalls the pipeline.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, word width.
- `BURST_LEN`, 4, beats per line; power of two, at least 1.
- `clk_i` input 1: the block's single clock.
- `rst_i` input 1: synchronous, active-high reset.
- `i_req_i` input 1: I-cache burst request; held until `i_done_o`.
- `i_addr_i` input ADDR_WIDTH: I-cache line base address, line-aligned.
- `i_rdata_o` output DATA_WIDTH: read data to the I-cache.
- `i_valid_o` output 1: a beat completed for the I-cache.
- `i_done_o` output 1: last beat of the I-cache burst.
- `d_req_i` input 1: D-cache burst request; held until `d_done_o`.
- `d_we_i` input 1: D-cache burst is a write-back when high, a refill when low.
- `d_addr_i` input ADDR_WIDTH: D-cache line base address.
- `d_wdata_i` input DATA_WIDTH: write data for the beat selected by `beat_o`.
- `d_rdata_o` output DATA_WIDTH: read data to the D-cache.
- `d_valid_o` output 1: a beat completed for the D-cache.
- `d_done_o` output 1: last beat of the D-cache burst.
- `beat_o` output max(1,$clog2(BURST_LEN)): current beat index.
- `mem_req_o` output 1: memory beat request.
- `mem_we_o` output 1: memory write enable.
- `mem_addr_o` output ADDR_WIDTH: beat address.
- `mem_wdata_o` output DATA_WIDTH: beat write data.
- `mem_rdata_i` input DATA_WIDTH: memory read data, valid while `mem_ack_i` is high.
- `mem_ack_i` input 1: current beat accepted or completed.

## Operation
- **States:** IDLE, GRANT_I, GRANT_D.
- **In IDLE:**
  - Sample the requests.
  - The winner per the priority policy (see Configuration) moves the FSM to its GRANT state at the next edge.
  - Latch the winner's address and `we` into registers, and clear the beat counter.
  - With no request, stay in IDLE.
- **In GRANT state:**
  - `mem_req_o`=1.
  - `mem_addr_o` = latched base + (beat << 2), computed in ADDR_WIDTH and wrapping modulo 2^ADDR_WIDTH.
  - `mem_we_o` = latched `we`; always 0 in GRANT_I.
  - `mem_wdata_o` = `d_wdata_i` in GRANT_D, otherwise 0.
- **Beat completion:** on `mem_ack_i`, the granted requester sees valid=1 combinationally and rdata=`mem_rdata_i` in the same cycle, and the beat counter increments at the edge.
- **Last beat:** on the ack with beat == BURST_LEN-1, `done`=1 in the same cycle and the FSM returns to IDLE.
  - The counter wraps to 0.
  - There is always at least one IDLE cycle between bursts.
- **Non-granted requester:** its valid/done/rdata stay 0.
- **Write bursts:** `d_valid_o` pulses per beat as a write acknowledge. `d_rdata_o` is a don't-care and is driven 0.
- **Request withdrawal:** `req` deasserted mid-burst is ignored; the burst completes.
- **Requests after done:** a `req` still high in the IDLE cycle after `done` is a new request.

## Timing
- Request seen in cycle 0 (IDLE) → `mem_req_o` high in cycle 1.
- Minimum burst = 1 + BURST_LEN cycles when `mem_ack_i` is high every cycle.
- Wait states: `mem_ack_i` low holds the beat, address and data stable.
- Reset values: all outputs 0, state IDLE, counter 0, priority pointer pointing to D.
- Reset mid-burst: at the next edge all outputs are 0 and the FSM is in IDLE. The in-flight burst is abandoned without a done.
- Simultaneous requests in IDLE are resolved in a single cycle; no cycle is lost.

## Configuration
- Macro `MEM_ARB_RR_EN`.
- **Defined:** round-robin.
  - A one-bit pointer names the favoured requester.
  - After each completed burst, the pointer flips to the other requester.
  - On a tie, the favoured requester wins.
- **Undefined:** fixed priority. D beats I on a tie, because data misses come from the older instruction; the pointer is absent.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_e` (IDLE, GRANT_I, GRANT_D).
  - `arb_src_e` (SRC_I, SRC_D).
  - Constant `WORD_BYTES` = 4.
- Sub-module `mem_arb_pick`: combinational winner selection from the two requests and the pointer. It is the only place the macro is tested.
- Top level holds the FSM, beat counter, latched address/`we` and output muxing.

## Test plan
- **I-only refill:** `i_req_i`=1, `i_addr_i`=0x100, ack every cycle → mem addresses 0x100, 0x104, 0x108, 0x10C in cycles 1–4; `i_done_o` in cycle 4; IDLE in cycle 5.
- **D write-back with waits:** `d_we_i`=1, `d_addr_i`=0x2000, ack low for 2 cycles per beat → `mem_we_o`=1 throughout; each beat's address and data are held for 3 cycles; 4 `d_valid_o` pulses.
- **Simultaneous requests, macro undefined:** both requests at once, both held → D served first (0x40), then I (0x80), then D again.
- **Simultaneous requests, `MEM_ARB_RR_EN` defined:** both held continuously → grants alternate D, I, D, I.
- **Reset in beat 2 of an I burst:** `rst_i` pulsed → next cycle `mem_req_o`=0, no `i_done_o`, state IDLE; re-request restarts at beat 0.
- **Address wrap:** `i_addr_i`=0xFFFFFFF8, BURST_LEN=4 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the I- and D-cache requests.
// Optional feature macro: MEM_ARB_RR_EN (round-robin with a one-bit pointer); otherwise D wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_burst_done,
  input  logic i_i_req,
  input  logic i_d_req,
  output logic o_win_valid,
  output logic o_win_d
);

`ifdef MEM_ARB_RR_EN
  arb_src_e r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= SRC_D;
    end else if (i_burst_done) begin
      r_ptr <= (r_ptr == SRC_D) ? SRC_I : SRC_D;
    end
  end

  always_comb begin
    o_win_valid = i_i_req | i_d_req;
    o_win_d     = (i_i_req && i_d_req) ? (r_ptr == SRC_D) : i_d_req;
  end
`else
  // Clock, reset and burst-done only feed the pointer, which fixed priority does not have.
  logic w_unused_pick;
  assign w_unused_pick = ^{i_clk, i_rst, i_burst_done};

  always_comb begin
    o_win_valid = i_i_req | i_d_req;
    o_win_d     = i_d_req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache and D-cache line bursts.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration, see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4,
  localparam int unsigned BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  i_valid_o,
  output logic                  i_done_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_valid_o,
  output logic                  d_done_o,
  output logic [BEAT_W-1:0]     beat_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  arb_state_e            r_state;
  arb_state_e            w_next_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_we;
  logic [BEAT_W-1:0]     r_beat;

  logic w_win_valid;
  logic w_win_d;
  logic w_granted;
  logic w_last;
  logic w_beat_done;
  logic w_burst_done;

  assign w_granted    = (r_state != IDLE);
  assign w_last       = (r_beat == LAST_BEAT);
  assign w_beat_done  = w_granted && mem_ack_i;
  assign w_burst_done = w_beat_done && w_last;

  mem_arb_pick u_pick (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_burst_done (w_burst_done),
    .i_i_req      (i_req_i),
    .i_d_req      (d_req_i),
    .o_win_valid  (w_win_valid),
    .o_win_d      (w_win_d)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_next_state = w_win_d ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (w_burst_done) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_base  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        r_beat <= '0;
        if (w_win_valid) begin
          r_base <= w_win_d ? d_addr_i : i_addr_i;
          r_we   <= w_win_d & d_we_i;
        end
      end else if (mem_ack_i) begin
        r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
    end
  end

  // Everything is gated by the grant so IDLE (and hence reset) drives all zeros.
  always_comb begin
    mem_req_o   = w_granted;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    i_valid_o   = 1'b0;
    i_done_o    = 1'b0;
    i_rdata_o   = '0;
    d_valid_o   = 1'b0;
    d_done_o    = 1'b0;
    d_rdata_o   = '0;
    beat_o      = r_beat;
    if (w_granted) begin
      mem_addr_o = r_base + (ADDR_WIDTH'(r_beat) << WORD_SHIFT);
    end
    if (r_state == GRANT_I) begin
      i_valid_o = mem_ack_i;
      i_done_o  = w_burst_done;
      if (mem_ack_i) begin
        i_rdata_o = mem_rdata_i;
      end
    end
    if (r_state == GRANT_D) begin
      mem_we_o    = r_we;
      mem_wdata_o = d_wdata_i;
      d_valid_o   = mem_ack_i;
      d_done_o    = w_burst_done;
      if (mem_ack_i && !r_we) begin
        d_rdata_o = mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario table plus hand-written reset and withdrawal sequences.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 4;
  localparam int unsigned BW = 2;

  logic          clk;
  logic          rst_i;
  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic [DW-1:0] i_rdata_o;
  logic          i_valid_o;
  logic          i_done_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_valid_o;
  logic          d_done_o;
  logic [BW-1:0] beat_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .i_req_i     (i_req_i),
    .i_addr_i    (i_addr_i),
    .i_rdata_o   (i_rdata_o),
    .i_valid_o   (i_valid_o),
    .i_done_o    (i_done_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_rdata_o   (d_rdata_o),
    .d_valid_o   (d_valid_o),
    .d_done_o    (d_done_o),
    .beat_o      (beat_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   addr;
    logic          we;
    logic          is_d;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [BW-1:0] beat;
    logic          done;
  } beat_t;

  typedef struct {
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic        d_we;
    int          i_n;
    int          d_n;
    int          i_gap;
    int          d_gap;
    int          waits;
    int          n;
    logic [3:0]  order;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[6];

  int checks = 0;
  int errors = 0;
  int waits = 0;
  int wcnt = 0;
  int cyc = 0;
  int first_done = -1;
  int i_left = 0;
  int d_left = 0;
  int i_gap = 0;
  int d_gap = 0;
  int i_gcnt = 0;
  int d_gcnt = 0;
  bit auto_req = 1'b0;
  bit prev_done = 1'b0;

  function automatic logic [31:0] rd_of(logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] wd_of(logic [BW-1:0] b);
    return {16'hC0DE, 8'hA0, 6'd0, b};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(logic is_d, logic [31:0] base, logic we);
    beat_t e;
    for (int b = 0; b < BL; b++) begin
      e.is_d  = is_d;
      e.addr  = base + 32'(b * 4);
      e.we    = we;
      e.beat  = BW'(b);
      e.wdata = is_d ? wd_of(BW'(b)) : 32'h0;
      e.rdata = rd_of(e.addr);
      e.done  = (b == BL - 1);
      sb.push_back(e);
    end
  endtask

  // One clock cycle: memory model, scoreboard monitor, then the cache request model.
  task automatic step();
    beat_t e;
    @(negedge clk);
    cyc++;
    mem_ack_i   = mem_req_o && (wcnt >= waits);
    mem_rdata_i = mem_ack_i ? rd_of(mem_addr_o) : 32'hBAD0_BAD0;
    d_wdata_i   = wd_of(beat_o);
    #1;
    if (prev_done) chk("idle_after_done", 32'(mem_req_o), 32'd0);
    if (mem_req_o && mem_ack_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got beat at addr %h expected none", mem_addr_o);
      end else begin
        e = sb.pop_front();
        chk("addr", mem_addr_o, e.addr);
        chk("we", 32'(mem_we_o), 32'(e.we));
        chk("wdata", mem_wdata_o, e.wdata);
        chk("beat", 32'(beat_o), 32'(e.beat));
        chk("i_valid", 32'(i_valid_o), 32'(!e.is_d));
        chk("d_valid", 32'(d_valid_o), 32'(e.is_d));
        chk("i_done", 32'(i_done_o), 32'(!e.is_d && e.done));
        chk("d_done", 32'(d_done_o), 32'(e.is_d && e.done));
        chk("i_rdata", i_rdata_o, e.is_d ? 32'h0 : e.rdata);
        chk("d_rdata", d_rdata_o, (e.is_d && !e.we) ? e.rdata : 32'h0);
      end
      wcnt = 0;
    end else begin
      chk("valid_idle", 32'({i_valid_o, d_valid_o, i_done_o, d_done_o}), 32'd0);
      if (mem_req_o) begin
        if (sb.size() > 0) begin
          chk("hold_addr", mem_addr_o, sb[0].addr);
          chk("hold_wdata", mem_wdata_o, sb[0].wdata);
          chk("hold_we", 32'(mem_we_o), 32'(sb[0].we));
        end
        wcnt++;
      end else begin
        chk("idle_zero", mem_addr_o | mem_wdata_o | i_rdata_o | d_rdata_o, 32'd0);
        wcnt = 0;
      end
    end
    prev_done = i_done_o | d_done_o;
    if ((i_done_o | d_done_o) && first_done < 0) first_done = cyc;
    if (auto_req) begin
      if (i_done_o) begin
        i_left--;
        i_gcnt  = i_gap;
        i_req_i = (i_left > 0) && (i_gcnt == 0);
      end else if (i_gcnt > 0) begin
        i_gcnt--;
        i_req_i = 1'b0;
      end else begin
        i_req_i = (i_left > 0);
      end
      if (d_done_o) begin
        d_left--;
        d_gcnt  = d_gap;
        d_req_i = (d_left > 0) && (d_gcnt == 0);
      end else if (d_gcnt > 0) begin
        d_gcnt--;
        d_req_i = 1'b0;
      end else begin
        d_req_i = (d_left > 0);
      end
    end
  endtask

  task automatic do_reset();
    auto_req  = 1'b0;
    i_req_i   = 1'b0;
    d_req_i   = 1'b0;
    rst_i     = 1'b1;
    sb.delete();
    prev_done = 1'b0;
    wcnt      = 0;
    step();
    step();
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_beat", 32'(beat_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    rst_i      = 1'b0;
    cyc        = 0;
    first_done = -1;
  endtask

  task automatic drain(string name, int budget);
    for (int t = 0; t < budget && !(sb.size() == 0 && i_left <= 0 && d_left <= 0); t++) step();
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_vec(vec_t v);
    do_reset();
    waits    = v.waits;
    i_addr_i = v.i_addr;
    d_addr_i = v.d_addr;
    d_we_i   = v.d_we;
    for (int k = 0; k < v.n; k++)
      push_burst(v.order[k], v.order[k] ? v.d_addr : v.i_addr, v.order[k] & v.d_we);
    i_left   = v.i_n;
    d_left   = v.d_n;
    i_gap    = v.i_gap;
    d_gap    = v.d_gap;
    i_gcnt   = 0;
    d_gcnt   = 0;
    auto_req = 1'b1;
    i_req_i  = (i_left > 0);
    d_req_i  = (d_left > 0);
    drain("vec", 400);
    chk("bursts_left", 32'(i_left + d_left), 32'd0);
    if (v.n == 1) chk("done_cycle", 32'(first_done), 32'(BL * (v.waits + 1)));
    auto_req = 1'b0;
    i_req_i  = 1'b0;
    d_req_i  = 1'b0;
    step();
  endtask

  initial begin
    rst_i       = 1'b1;
    i_req_i     = 1'b0;
    d_req_i     = 1'b0;
    d_we_i      = 1'b0;
    i_addr_i    = '0;
    d_addr_i    = '0;
    d_wdata_i   = '0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;

    vecs[0] = '{i_addr: 32'h0000_0100, d_addr: 32'h0, d_we: 1'b0, i_n: 1, d_n: 0,
                i_gap: 0, d_gap: 0, waits: 0, n: 1, order: 4'b0000};
    vecs[1] = '{i_addr: 32'h0, d_addr: 32'h0000_2000, d_we: 1'b1, i_n: 0, d_n: 1,
                i_gap: 0, d_gap: 0, waits: 2, n: 1, order: 4'b0001};
    // D wins the tie in both modes; D drops for one cycle after its burst so I gets in, then D returns.
    vecs[2] = '{i_addr: 32'h0000_0080, d_addr: 32'h0000_0040, d_we: 1'b0, i_n: 1, d_n: 2,
                i_gap: 0, d_gap: 1, waits: 0, n: 3, order: 4'b0101};
`ifdef MEM_ARB_RR_EN
    vecs[3] = '{i_addr: 32'h0000_1000, d_addr: 32'h0000_3000, d_we: 1'b0, i_n: 2, d_n: 2,
                i_gap: 0, d_gap: 0, waits: 1, n: 4, order: 4'b0101};
`else
    vecs[3] = '{i_addr: 32'h0000_1000, d_addr: 32'h0000_3000, d_we: 1'b0, i_n: 2, d_n: 2,
                i_gap: 0, d_gap: 0, waits: 1, n: 4, order: 4'b0011};
`endif
    vecs[4] = '{i_addr: 32'hFFFF_FFF8, d_addr: 32'h0, d_we: 1'b0, i_n: 1, d_n: 0,
                i_gap: 0, d_gap: 0, waits: 1, n: 1, order: 4'b0000};
    vecs[5] = '{i_addr: 32'h0, d_addr: 32'h0000_7FF0, d_we: 1'b0, i_n: 0, d_n: 1,
                i_gap: 0, d_gap: 0, waits: 3, n: 1, order: 4'b0001};

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Reset asserted in the cycle beat 2 of an I refill completes; the request then restarts at beat 0.
    do_reset();
    waits    = 0;
    i_addr_i = 32'h0000_0500;
    push_burst(1'b0, 32'h0000_0500, 1'b0);
    i_req_i  = 1'b1;
    for (int t = 0; t < 20 && sb.size() > 1; t++) step();
    chk("beats_before_rst", 32'(sb.size()), 32'd1);
    rst_i = 1'b1;
    sb.delete();
    step();
    chk("rst_mid_req", 32'(mem_req_o), 32'd0);
    chk("rst_mid_done", 32'(i_done_o), 32'd0);
    chk("rst_mid_beat", 32'(beat_o), 32'd0);
    rst_i      = 1'b0;
    cyc        = 0;
    first_done = -1;
    push_burst(1'b0, 32'h0000_0500, 1'b0);
    i_left   = 1;
    d_left   = 0;
    i_gap    = 0;
    i_gcnt   = 0;
    d_gcnt   = 0;
    auto_req = 1'b1;
    drain("rst_restart", 100);
    chk("rst_restart_done", 32'(first_done), 32'(BL));
    auto_req = 1'b0;
    i_req_i  = 1'b0;

    // Request withdrawn after the first cycle of a D refill: the burst still runs to completion.
    do_reset();
    waits    = 1;
    d_addr_i = 32'h0000_6000;
    d_we_i   = 1'b0;
    push_burst(1'b1, 32'h0000_6000, 1'b0);
    d_req_i  = 1'b1;
    step();
    d_req_i  = 1'b0;
    i_left   = 0;
    d_left   = 0;
    for (int t = 0; t < 100 && sb.size() > 0; t++) step();
    chk("withdraw_drained", 32'(sb.size()), 32'd0);
    step();
    step();
    chk("withdraw_no_rearm", 32'(mem_req_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
